pc_seq: RTL and testbench
=========================

Name: pc_seq

Overview:
- Control sequencer for the fetch-stage program counter.
- Takes pipeline events (instruction-memory busy, decode hazard, resolved branch/jump, halt, exception, RTI) and drives the PC's select and stall controls every cycle.
- Also drives the IF/ID flush and holds the exception return address (EPC).
- Sits between the hazard/execute logic and the PC register block in the fetch stage.

Parameters:
- FLUSH_CYCLES, 2, number of cycles Flush stays asserted after a redirect (legal range 1..7).
- EXC_VECTOR, 16'h0002, exception handler address. Reported only on EpcVec; the PC block hardwires the same value.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- IMemStall  in  1  instruction memory not ready this cycle
- HazStall  in  1  decode load-use hazard; hold fetch
- BrTaken  in  1  taken branch/J/JAL resolved this cycle (PC-relative redirect)
- JrTaken  in  1  JR/JALR resolved this cycle (register redirect)
- HaltReq  in  1  HALT instruction reached commit
- SiicReq  in  1  illegal-instruction exception at commit
- RtiReq  in  1  RTI at commit
- CurPC  in  16  PC of the instruction raising SiicReq
- PcSel  out  1  PC-relative redirect select
- RegJmp  out  1  register-jump select
- Halt  out  1  hold PC permanently
- SIIC  out  1  load exception vector
- PcStall  out  1  hold PC this cycle
- Flush  out  1  squash IF/ID contents
- Rti  out  1  integration mux selects Epc as next PC
- Epc  out  16  saved exception return address
- EpcVec  out  16  constant EXC_VECTOR
- StallCnt  out  16  stall-cycle count (see optional feature)

Behaviour:
States: RUN, STALL, FLUSH, EXC, HALTED. FSM state, flush counter and Epc are all registered. Select/stall outputs are combinational from the current state and the current inputs.

Reset (rst high at a clock edge):
- State goes to RUN, flush counter to 0, Epc to 16'h0000.
- All 1-bit outputs are 0 during and after reset until an event occurs.
- A mid-operation reset from any state takes effect at the next edge and overrides all inputs.

Priority per cycle, highest first: HaltReq > SiicReq > RtiReq > JrTaken > BrTaken > (IMemStall | HazStall).

Event handling in RUN or STALL:
- HaltReq:
  - Halt=1 the same cycle; next state HALTED.
  - HALTED is terminal: Halt stays 1 and all other outputs are 0 until rst.
- SiicReq:
  - SIIC=1 and Flush=1 the same cycle; Epc <= CurPC + 2 at the edge.
  - Next state EXC. EXC lasts 1 cycle with Flush=1 and all selects 0, then RUN.
  - SiicReq while in EXC is ignored.
- RtiReq:
  - Rti=1 and Flush=1 for 1 cycle; PC selects 0 and PcStall=0.
  - Next state FLUSH with counter = FLUSH_CYCLES-1.
- JrTaken:
  - RegJmp=1, PcSel=0, Flush=1.
  - Next state FLUSH with counter = FLUSH_CYCLES-1, or RUN if FLUSH_CYCLES=1.
- BrTaken:
  - PcSel=1, Flush=1; same transition as JrTaken.
  - If BrTaken and JrTaken arrive together, JrTaken wins.
- Stall (IMemStall or HazStall), no redirect:
  - PcStall=1; state goes to STALL.
  - STALL returns to RUN in the first cycle both stall inputs are low; that cycle behaves as RUN (PcStall=0).
- Redirect vs. stall:
  - A redirect arriving while stalled is never lost: redirect outputs assert and PcStall=0.
  - The PC block already ignores PcStall on the PC-relative path; this block forces PcStall=0 on every redirect for consistency.

FLUSH state:
- Flush=1, all selects 0.
- PcStall follows IMemStall|HazStall.
- The counter decrements each non-stalled cycle; at 0 the next state is RUN.
- A new redirect, halt or exception in FLUSH is handled exactly as in RUN and restarts the counter.

Invariants:
- At most one of PcSel, RegJmp, Halt, SIIC is 1 in any cycle.
- Rti=1 implies all four are 0.
- Epc arithmetic is 16-bit and wraps (CurPC=16'hFFFE gives Epc=16'h0000).

Optional Feature:
- Macro: PC_SEQ_PERF_EN.
- Defined:
  - StallCnt increments by 1 on each cycle with PcStall=1, saturating at 16'hFFFF.
  - It is cleared by rst and does not count in HALTED.
- Undefined:
  - StallCnt is tied to 16'h0000 and no counter register is built.

Test Plan:
1. Reset then idle inputs for 5 cycles -> all 1-bit outputs 0, Epc=0000, EpcVec=0002, state RUN.
2. IMemStall high for 3 cycles, then low -> PcStall=1 for exactly those 3 cycles, 0 on the 4th; StallCnt=3 when PC_SEQ_PERF_EN is defined, 0 when undefined.
3. BrTaken pulse with FLUSH_CYCLES=2 -> PcSel=1 and Flush=1 on cycle 0, Flush=1 on cycle 1, Flush=0 on cycle 2. BrTaken and JrTaken together -> RegJmp=1, PcSel=0.
4. SiicReq with CurPC=16'h0040 -> SIIC=1 and Flush=1 that cycle, Epc=0042 after the edge; a later RtiReq -> Rti=1 for 1 cycle and Epc stays 0042. Repeat with CurPC=FFFE -> Epc=0000.
5. HaltReq together with SiicReq and HazStall -> Halt=1, SIIC=0; Halt stays 1 for 10 cycles under random inputs; rst returns to RUN with Halt=0.
6. rst asserted mid-FLUSH together with BrTaken -> after the edge all outputs 0, Flush=0, counter 0.

Source files
------------

// File: rtl/pc_seq.sv
// pc_seq: fetch-stage PC control sequencer (redirect/stall/flush/exception/halt)
// Inputs: IMemStall, HazStall, BrTaken, JrTaken, HaltReq, SiicReq, RtiReq, CurPC.
// Outputs: PcSel, RegJmp, Halt, SIIC, PcStall, Flush, Rti, Epc, EpcVec, StallCnt.
// PC_SEQ_PERF_EN builds a saturating stall-cycle counter on StallCnt.
module pc_seq #(
  parameter int          FLUSH_CYCLES = 2,
  parameter logic [15:0] EXC_VECTOR   = 16'h0002
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        IMemStall,
  input  logic        HazStall,
  input  logic        BrTaken,
  input  logic        JrTaken,
  input  logic        HaltReq,
  input  logic        SiicReq,
  input  logic        RtiReq,
  input  logic [15:0] CurPC,
  output logic        PcSel,
  output logic        RegJmp,
  output logic        Halt,
  output logic        SIIC,
  output logic        PcStall,
  output logic        Flush,
  output logic        Rti,
  output logic [15:0] Epc,
  output logic [15:0] EpcVec,
  output logic [15:0] StallCnt
);
  typedef enum logic [2:0] {RUN, STALL, FLUSH, EXC, HALTED} state_t;
  localparam logic [2:0] CNT_INIT = 3'(FLUSH_CYCLES - 1);
  state_t      r_state, w_next;
  logic [2:0]  r_cnt, w_cnt;
  logic [15:0] r_epc;
  logic        w_stall;
  assign w_stall = IMemStall | HazStall;
  assign Epc     = r_epc;
  assign EpcVec  = EXC_VECTOR;
  always_comb begin
    Halt    = 1'b0;
    SIIC    = 1'b0;
    Rti     = 1'b0;
    RegJmp  = 1'b0;
    PcSel   = 1'b0;
    PcStall = 1'b0;
    Flush   = 1'b0;
    w_next  = r_state;
    w_cnt   = r_cnt;
    if (r_state == HALTED)
      Halt = 1'b1;
    else if (r_state == EXC) begin
      Flush  = 1'b1;
      w_next = RUN;
    end else if (HaltReq) begin
      Halt   = 1'b1;
      w_next = HALTED;
    end else if (SiicReq) begin
      SIIC   = 1'b1;
      Flush  = 1'b1;
      w_next = EXC;
    end else if (RtiReq | JrTaken | BrTaken) begin
      Rti    = RtiReq;
      RegJmp = !RtiReq && JrTaken;
      PcSel  = !RtiReq && !JrTaken;
      Flush  = 1'b1;
      w_next = (FLUSH_CYCLES == 1) ? RUN : FLUSH;
      w_cnt  = CNT_INIT;
    end else if (r_state == FLUSH) begin
      Flush   = 1'b1;
      PcStall = w_stall;
      w_cnt   = w_stall ? r_cnt : r_cnt - 3'd1;
      w_next  = (!w_stall && r_cnt == 3'd1) ? RUN : FLUSH;
    end else begin
      PcStall = w_stall;
      w_next  = w_stall ? STALL : RUN;
    end
    if (rst) begin
      Halt    = 1'b0;
      SIIC    = 1'b0;
      Rti     = 1'b0;
      RegJmp  = 1'b0;
      PcSel   = 1'b0;
      PcStall = 1'b0;
      Flush   = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
      r_cnt   <= 3'd0;
      r_epc   <= 16'h0000;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt;
      if (SIIC) r_epc <= CurPC + 16'd2;
    end
  end
`ifdef PC_SEQ_PERF_EN
  logic [15:0] r_stall_cnt;
  always_ff @(posedge clk) begin
    if (rst) r_stall_cnt <= 16'h0000;
    else if (PcStall && r_stall_cnt != 16'hFFFF) r_stall_cnt <= r_stall_cnt + 16'd1;
  end
  assign StallCnt = r_stall_cnt;
`else
  assign StallCnt = 16'h0000;
`endif
endmodule

// File: tb/tb_pc_seq.sv
// tb_pc_seq: randomized and directed checks of pc_seq against a behavioural model
module tb_pc_seq;
  localparam int FC = 2;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, IMemStall, HazStall, BrTaken, JrTaken, HaltReq, SiicReq, RtiReq;
  logic [15:0] CurPC;
  logic PcSel, RegJmp, Halt, SIIC, PcStall, Flush, Rti;
  logic [15:0] Epc, EpcVec, StallCnt;
  pc_seq #(.FLUSH_CYCLES(FC), .EXC_VECTOR(16'h0002)) dut (
    .clk(clk), .rst(rst), .IMemStall(IMemStall), .HazStall(HazStall), .BrTaken(BrTaken),
    .JrTaken(JrTaken), .HaltReq(HaltReq), .SiicReq(SiicReq), .RtiReq(RtiReq), .CurPC(CurPC),
    .PcSel(PcSel), .RegJmp(RegJmp), .Halt(Halt), .SIIC(SIIC), .PcStall(PcStall), .Flush(Flush),
    .Rti(Rti), .Epc(Epc), .EpcVec(EpcVec), .StallCnt(StallCnt)
  );
  int passed = 0, total = 0;
  bit m_halted, m_exc;
  int m_flush_left;
  logic [15:0] m_epc, m_sc;
  logic l_pcsel, l_regjmp, l_halt, l_siic, l_pcstall, l_flush, l_rti;
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask
  task automatic idle();
    rst = 0; IMemStall = 0; HazStall = 0; BrTaken = 0; JrTaken = 0;
    HaltReq = 0; SiicReq = 0; RtiReq = 0; CurPC = 16'h0000;
  endtask
  task automatic cyc();
    logic e_pcsel, e_regjmp, e_halt, e_siic, e_pcstall, e_flush, e_rti;
    @(negedge clk);
    {e_pcsel, e_regjmp, e_halt, e_siic, e_pcstall, e_flush, e_rti} = '0;
    if (rst) ;
    else if (m_halted) e_halt = 1;
    else if (m_exc) e_flush = 1;
    else if (HaltReq) e_halt = 1;
    else if (SiicReq) begin e_siic = 1; e_flush = 1; end
    else if (RtiReq) begin e_rti = 1; e_flush = 1; end
    else if (JrTaken) begin e_regjmp = 1; e_flush = 1; end
    else if (BrTaken) begin e_pcsel = 1; e_flush = 1; end
    else begin e_pcstall = IMemStall | HazStall; e_flush = m_flush_left > 0; end
    {l_pcsel, l_regjmp, l_halt, l_siic, l_pcstall, l_flush, l_rti} =
      {PcSel, RegJmp, Halt, SIIC, PcStall, Flush, Rti};
    chk("PcSel", {15'd0, PcSel}, {15'd0, e_pcsel});
    chk("RegJmp", {15'd0, RegJmp}, {15'd0, e_regjmp});
    chk("Halt", {15'd0, Halt}, {15'd0, e_halt});
    chk("SIIC", {15'd0, SIIC}, {15'd0, e_siic});
    chk("PcStall", {15'd0, PcStall}, {15'd0, e_pcstall});
    chk("Flush", {15'd0, Flush}, {15'd0, e_flush});
    chk("Rti", {15'd0, Rti}, {15'd0, e_rti});
    chk("Epc", Epc, m_epc);
    chk("EpcVec", EpcVec, 16'h0002);
    chk("StallCnt", StallCnt, m_sc);
    if (rst) begin
      m_halted = 0; m_exc = 0; m_flush_left = 0; m_epc = 16'h0000; m_sc = 16'h0000;
    end else begin
`ifdef PC_SEQ_PERF_EN
      if (e_pcstall && m_sc != 16'hFFFF) m_sc = m_sc + 16'd1;
`endif
      if (m_halted) ;
      else if (m_exc) m_exc = 0;
      else if (HaltReq) m_halted = 1;
      else if (SiicReq) begin m_exc = 1; m_flush_left = 0; m_epc = CurPC + 16'd2; end
      else if (RtiReq | JrTaken | BrTaken) m_flush_left = FC - 1;
      else if (!e_pcstall && m_flush_left > 0) m_flush_left--;
    end
    @(posedge clk);
    #1;
  endtask
  task automatic rand_inputs(input int rst_odds);
    rst = ($urandom_range(rst_odds - 1) == 0);
    IMemStall = ($urandom_range(3) == 0);
    HazStall = ($urandom_range(5) == 0);
    BrTaken = ($urandom_range(7) == 0);
    JrTaken = ($urandom_range(11) == 0);
    HaltReq = ($urandom_range(79) == 0);
    SiicReq = ($urandom_range(29) == 0);
    RtiReq = ($urandom_range(19) == 0);
    CurPC = ($urandom_range(7) == 0) ? 16'hFFFE : 16'($urandom);
  endtask
  initial begin
    m_halted = 0; m_exc = 0; m_flush_left = 0; m_epc = 16'h0000; m_sc = 16'h0000;
    idle();
    rst = 1;
    @(posedge clk); #1;
    cyc();
    idle();
    repeat (5) cyc();
    chk("epcvec_lit", EpcVec, 16'h0002);
    chk("epc_reset_lit", Epc, 16'h0000);
    chk("flush_idle_lit", {15'd0, l_flush}, 16'd0);
    IMemStall = 1;
    repeat (3) begin cyc(); chk("stall_on_lit", {15'd0, l_pcstall}, 16'd1); end
    IMemStall = 0;
    cyc();
    chk("stall_off_lit", {15'd0, l_pcstall}, 16'd0);
`ifdef PC_SEQ_PERF_EN
    chk("stallcnt_lit", StallCnt, 16'd3);
`else
    chk("stallcnt_lit", StallCnt, 16'd0);
`endif
    BrTaken = 1;
    cyc();
    chk("br_pcsel_lit", {15'd0, l_pcsel}, 16'd1);
    chk("br_flush0_lit", {15'd0, l_flush}, 16'd1);
    BrTaken = 0;
    cyc();
    chk("br_flush1_lit", {15'd0, l_flush}, 16'd1);
    cyc();
    chk("br_flush2_lit", {15'd0, l_flush}, 16'd0);
    BrTaken = 1; JrTaken = 1;
    cyc();
    chk("brjr_regjmp_lit", {15'd0, l_regjmp}, 16'd1);
    chk("brjr_pcsel_lit", {15'd0, l_pcsel}, 16'd0);
    idle();
    repeat (2) cyc();
    SiicReq = 1; CurPC = 16'h0040;
    cyc();
    chk("siic_lit", {15'd0, l_siic}, 16'd1);
    idle();
    chk("epc_0042_lit", Epc, 16'h0042);
    cyc();
    chk("exc_flush_lit", {15'd0, l_flush}, 16'd1);
    repeat (2) cyc();
    RtiReq = 1;
    cyc();
    chk("rti_lit", {15'd0, l_rti}, 16'd1);
    idle();
    cyc();
    chk("rti_pulse_lit", {15'd0, l_rti}, 16'd0);
    chk("epc_kept_lit", Epc, 16'h0042);
    repeat (2) cyc();
    SiicReq = 1; CurPC = 16'hFFFE;
    cyc();
    idle();
    chk("epc_wrap_lit", Epc, 16'h0000);
    repeat (3) cyc();
    HaltReq = 1; SiicReq = 1; HazStall = 1;
    cyc();
    chk("halt_pri_lit", {15'd0, l_halt}, 16'd1);
    chk("halt_nosiic_lit", {15'd0, l_siic}, 16'd0);
    repeat (10) begin
      rand_inputs(1 << 30);
      rst = 0;
      cyc();
      chk("halt_hold_lit", {15'd0, l_halt}, 16'd1);
    end
    idle(); rst = 1;
    cyc();
    idle();
    cyc();
    chk("halt_cleared_lit", {15'd0, l_halt}, 16'd0);
    BrTaken = 1;
    cyc();
    idle(); rst = 1; BrTaken = 1;
    cyc();
    chk("rst_mid_flush_lit", {15'd0, l_flush}, 16'd0);
    chk("rst_mid_pcsel_lit", {15'd0, l_pcsel}, 16'd0);
    idle();
    cyc();
    chk("after_rst_flush_lit", {15'd0, l_flush}, 16'd0);
    repeat (3000) begin
      rand_inputs(50);
      cyc();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
